// File: rtl/counter_load_arb.sv
// Round-robin owner arbiter for a shared loadable counter: grant, one-cycle load, run until all-ones.
// All outputs registered; load_o one cycle after a request is seen in IDLE, done_o one cycle after count_i hits all-ones.
module counter_load_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0]         count_i,
  output logic                     load_o,
  output logic [WIDTH-1:0]         load_val_o,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic                     busy_o,
  output logic                     done_o
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 load_q, load_d;
  logic [WIDTH-1:0]     val_q, val_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 win_vld;
  logic                 hi_vld;
  logic [PW-1:0]        hi_idx, lo_idx, win_idx;
  logic [WIDTH-1:0]     win_val;
  logic                 owner_req;
  logic                 cnt_full;

  // Lowest requester at or above ptr wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    hi_vld  = 1'b0;
    hi_idx  = '0;
    lo_idx  = '0;
    win_val = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_idx = PW'(i);
        if (PW'(i) >= ptr_q) begin
          hi_vld = 1'b1;
          hi_idx = PW'(i);
        end
      end
    end
    win_idx = hi_vld ? hi_idx : lo_idx;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PW'(i)) win_val = load_val_i[i*WIDTH +: WIDTH];
    end
  end

  assign win_vld   = |req_i;
  assign owner_req = |(req_i & gnt_q);
  assign cnt_full  = &count_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      load_q  <= 1'b0;
      val_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      load_q  <= load_d;
      val_q   <= val_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (!owner_req || cnt_full) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Abort (owner drops request) takes priority over completion.
  always_comb begin
    ptr_d  = ptr_q;
    load_d = 1'b0;
    val_d  = val_q;
    gnt_d  = gnt_q;
    busy_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (win_vld) begin
          gnt_d  = NUM_REQ'(1) << win_idx;
          val_d  = win_val;
          ptr_d  = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
          load_d = 1'b1;
          busy_d = 1'b1;
        end
      end
      LOAD: busy_d = 1'b1;
      RUN: begin
        if (!owner_req) begin
          gnt_d = '0;
        end else if (cnt_full) begin
          gnt_d  = '0;
          done_d = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: gnt_d = '0;
    endcase
  end

  assign load_o     = load_q;
  assign load_val_o = val_q;
  assign gnt_o      = gnt_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: doc/counter_load_arb.md
COUNTER_LOAD_ARB -- requirements
Module: counter_load_arb

Interface
REQ-001 The block SHALL have these parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 4, counter data width.

REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_i  in  NUM_REQ  per-requester request for counter ownership, level.
- load_val_i  in  NUM_REQ*WIDTH  per-requester start value; slice k = bits [k*WIDTH +: WIDTH].
- count_i  in  WIDTH  current value of the shared loadable counter.
- load_o  out  1  load strobe to the counter.
- load_val_o  out  WIDTH  load value to the counter.
- gnt_o  out  NUM_REQ  one-hot ownership grant.
- busy_o  out  1  high whenever a requester owns the counter.
- done_o  out  1  one-cycle pulse on normal completion of an ownership.

Function
REQ-003 The block SHALL implement the FSM states IDLE, LOAD and RUN, all outputs registered.

REQ-004 In IDLE with req_i != 0, the block SHALL select one winner by round-robin, searching upward (with wrap) from index ptr.

REQ-005 On that edge the block SHALL:
- capture the winner's load_val_i slice;
- set gnt_o to the winner's one-hot;
- set ptr to (winner+1) mod NUM_REQ;
- enter LOAD.

REQ-006 In IDLE with req_i == 0, the block SHALL hold state, and gnt_o, load_o and busy_o SHALL be 0.

REQ-007 In LOAD, the block SHALL:
- drive load_o=1 and load_val_o=captured value for exactly one cycle;
- keep gnt_o at the winner's one-hot;
- assert busy_o=1;
- enter RUN unconditionally.

REQ-008 In RUN, load_o SHALL be 0, gnt_o SHALL be held and busy_o SHALL be 1.

REQ-009 RUN exit priority:
- (a) owner's req_i bit low: go to IDLE, clear gnt_o and busy_o, done_o stays 0 (abort);
- (b) else, count_i == all-ones: go to IDLE, clear gnt_o and busy_o, pulse done_o=1 for one cycle;
- (c) else, remain in RUN.

REQ-010 Latency SHALL be:
- req seen in IDLE to load_o high: 1 cycle;
- count_i reaching all-ones to done_o high: 1 cycle.

REQ-011 A requester re-requesting after completion SHALL NOT win again while any other requester is pending (round-robin fairness).

REQ-012 Changes to load_val_i after grant SHALL NOT affect load_val_o for the current ownership.

REQ-013 Requests arriving during LOAD/RUN SHALL be ignored until the block returns to IDLE; no request is latched.

REQ-014 After completion or abort, the earliest new arbitration SHALL be evaluated in the IDLE cycle that follows, giving a minimum 1-cycle gap between ownerships.

REQ-015 A loaded value equal to all-ones SHALL complete after exactly one RUN cycle.

REQ-016 load_val_o SHALL retain its last value when load_o=0.

REQ-017 gnt_o SHALL never have more than one bit set.

Reset
REQ-018 While reset=0, the block SHALL asynchronously force:
- state=IDLE, ptr=0;
- load_o=0, load_val_o=0, gnt_o=0, busy_o=0, done_o=0.

REQ-019 A reset asserted during LOAD or RUN SHALL abort the ownership with no done_o pulse.

REQ-020 After reset release, arbitration SHALL start at index 0.

Verification
REQ-021 Single request:
- stimulus: req_i=0001, slice0=9;
- response: next cycle load_o=1, load_val_o=9, gnt_o=0001;
- then count_i 10..15 -> done_o pulses the cycle after count_i=15, gnt_o=0.

REQ-022 Contention:
- stimulus: req_i=1111 held, each ownership completed via count_i=15;
- response: grants in order 0001, 0010, 0100, 1000, 0001.

REQ-023 Abort:
- stimulus: owner 2 in RUN, req_i[2] dropped while count_i=5;
- response: next cycle gnt_o=0, busy_o=0, done_o stays 0.

REQ-024 Immediate completion:
- stimulus: slice1=15, req_i=0010;
- response: LOAD, one RUN cycle, then done_o=1.

REQ-025 Reset mid-RUN:
- stimulus: reset=0 while owner 3 is in RUN;
- response: all outputs 0 immediately;
- after release, req_i=1001 -> grant 0001.

REQ-026 Value capture:
- stimulus: slice0 changes 9->3 in the LOAD cycle;
- response: load_val_o=9.
